sap_cpu_core: RTL
=================

// Module: sap_cpu_core
// PURPOSE
//  Parametrised next-generation SAP-style accumulator CPU core with on-chip loadable RAM.
//  Widens datapath/address space and adds STA, LDI, jumps on carry/zero, halt and a run/load mode.
//  Sits under the tt_um_* top: ui/uio pins drive run and the program-load port; uo_out shows out_data.
// PARAMETERS
//  DATA_W  8  datapath, RAM word and instruction width; must be >= ADDR_W+4
//  ADDR_W  4  RAM address width; RAM depth = 2**ADDR_W words
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  run        in   1       1 = execute program, 0 = abort to IDLE/load mode
//  prog_we    in   1       RAM write strobe (honoured only in IDLE or HALTED)
//  prog_addr  in   ADDR_W  RAM write address
//  prog_data  in   DATA_W  RAM write data
//  out_data   out  DATA_W  output register (last OUT value)
//  out_valid  out  1       one-cycle pulse when out_data updates
//  halted     out  1       1 while in HALTED
//  pc_dbg     out  ADDR_W  current PC
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; PC, MAR, IR, A, B, C, Z, out_data all 0; out_valid=0,
//   halted=0. RAM contents are not reset. Reset mid-instruction aborts it immediately.
//  Instruction word: opcode = IR[DATA_W-1:DATA_W-4], operand = IR[ADDR_W-1:0].
//   0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI (A <= zero-ext IR[DATA_W-5:0]), 6 JMP, 7 JC,
//   8 JZ, E OUT, F HLT; 9-D execute as NOP.
//  RAM: combinational read of mem[MAR]; synchronous write.
//  FSM states IDLE, F0, F1, E0, E1, HALTED; one state per clk:
//   IDLE: run=1 -> F0. prog_we=1 writes mem[prog_addr] <= prog_data.
//   F0: MAR <= PC.   F1: IR <= mem[MAR]; PC <= PC+1 mod 2**ADDR_W.
//   E0: LDA/ADD/SUB/STA: MAR <= operand, -> E1. LDI: A <= imm. JMP: PC <= operand.
//       JC/JZ: PC <= operand if C/Z = 1, else PC unchanged. OUT: out_data <= A, out_valid = 1
//       for the following cycle. HLT -> HALTED. All other E0 cases -> F0.
//   E1: LDA: A <= mem[MAR]. ADD/SUB: B <= mem[MAR], A <= result. STA: mem[MAR] <= A. -> F0.
//  Latency: 4 clks for LDA/ADD/SUB/STA; 3 clks for all other opcodes.
//  Arithmetic: ADD {C,A} <= A + M; SUB {C,A} <= A + ~M + 1 (C=1 means no borrow), with
//   M = mem[MAR] and DATA_W+1-bit sums. Z <= (result == 0). Only ADD and SUB change C and Z;
//   LDA and LDI do not.
//  HALTED: halted=1, no further fetches. prog_we honoured. run=0 -> IDLE.
//  run=0 in F0/F1/E0/E1/HALTED -> IDLE next edge; PC, C, Z cleared; A and out_data retained;
//   any in-flight STA write is not performed.
//  prog_we is ignored in F0/F1/E0/E1. A STA to a program address is legal (self-modifying).
//  PC wraps from 2**ADDR_W-1 to 0 with no flag or stall.
// TESTING
//  1 mem: 0=LDA 14, 1=ADD 15, 2=OUT, 3=HLT; [14]=0x05, [15]=0x07; run=1
//    -> one out_valid pulse with out_data=0x0C; halted=1 after 14 clks of execution.
//  2 LDA 0x05; SUB 0x05; JZ 6; OUT; ... 6: LDI 3; OUT; HLT -> A=0, Z=1, C=1, jump taken,
//    single OUT = 0x03.
//  3 0xF0 + 0x20 -> A=0x10, C=1, Z=0. JC taken. Also 0x10 - 0x20 -> A=0xF0, C=0, JC not taken.
//  4 mem all NOP except [0]=OUT (A=0) -> pc_dbg counts 0..15, wraps to 0, out_valid pulses
//    every 48 clks.
//  5 rst_n low during E1 of STA -> target word unchanged; all outputs 0 asynchronously;
//    run again restarts from PC=0.
//  6 While running: prog_we=1 to addr 3 -> RAM unchanged. run=0 -> IDLE, PC=0, A retained;
//    a write is then accepted.

Source files
------------

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: SAP-style accumulator CPU with on-chip loadable RAM.
// Ports: clk, rst_n (async low); run (1=execute, 0=abort to IDLE/load);
//   prog_we/prog_addr/prog_data load RAM while IDLE or HALTED;
//   out_data (last OUT value), out_valid (1-cycle pulse), halted, pc_dbg.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_E0, S_E1, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_c;
    logic                r_z;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_halted;
    logic [DATA_W-1:0]   r_mem [0:2**ADDR_W-1];

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_operand;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_mem_rd;
    logic                w_is_sub;
    logic [DATA_W-1:0]   w_alu_b;
    logic [DATA_W:0]     w_sum;
    logic                w_abort;
    logic                w_prog_wr;
    logic                w_sta_wr;
    logic                w_unused_b;

    assign w_op      = r_ir[DATA_W-1:DATA_W-4];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_imm     = {4'b0000, r_ir[DATA_W-5:0]};
    assign w_mem_rd  = r_mem[r_mar];

    // SUB is A + ~M + 1, so carry out means "no borrow".
    assign w_is_sub = (w_op == OP_SUB);
    assign w_alu_b  = w_is_sub ? ~w_mem_rd : w_mem_rd;
    assign w_sum    = {1'b0, r_a} + {1'b0, w_alu_b}
                    + {{DATA_W{1'b0}}, w_is_sub};

    // Dropping run leaves any running state at the next edge.
    assign w_abort   = (r_state != S_IDLE) && !run;
    assign w_prog_wr = prog_we
                    && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_sta_wr  = (r_state == S_E1) && run && (w_op == OP_STA);

    // B is architectural state with no consumer inside this core.
    assign w_unused_b = ^r_b;

    always_ff @(posedge clk) begin
        if (w_prog_wr) begin
            r_mem[prog_addr] <= prog_data;
        end else if (w_sta_wr) begin
            r_mem[r_mar] <= r_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_abort) begin
                r_state  <= S_IDLE;
                r_pc     <= '0;
                r_c      <= 1'b0;
                r_z      <= 1'b0;
                r_halted <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run) r_state <= S_F0;
                    end
                    S_F0: begin
                        r_mar   <= r_pc;
                        r_state <= S_F1;
                    end
                    S_F1: begin
                        r_ir    <= w_mem_rd;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_state <= S_E0;
                    end
                    S_E0: begin
                        r_state <= S_F0;
                        case (w_op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                r_mar   <= w_operand;
                                r_state <= S_E1;
                            end
                            OP_LDI: r_a <= w_imm;
                            OP_JMP: r_pc <= w_operand;
                            OP_JC: if (r_c) r_pc <= w_operand;
                            OP_JZ: if (r_z) r_pc <= w_operand;
                            OP_OUT: begin
                                r_out_data  <= r_a;
                                r_out_valid <= 1'b1;
                            end
                            OP_HLT: begin
                                r_state  <= S_HALT;
                                r_halted <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    S_E1: begin
                        r_state <= S_F0;
                        case (w_op)
                            OP_LDA: r_a <= w_mem_rd;
                            OP_ADD, OP_SUB: begin
                                r_b <= w_mem_rd;
                                r_a <= w_sum[DATA_W-1:0];
                                r_c <= w_sum[DATA_W];
                                r_z <= (w_sum[DATA_W-1:0] == '0);
                            end
                            default: ;
                        endcase
                    end
                    S_HALT: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign halted    = r_halted;
    assign pc_dbg    = r_pc;

endmodule
